// File: rtl/hex_scan_display.sv
// N-digit time-multiplexed hex display driver: debounces a switch word, commits it, and
// scans the committed nibbles onto a shared 7-seg bus. Optional feature: LEADING_ZERO_BLANK_EN.
module hex_scan_display #(
    parameter int DIGITS          = 4,
    parameter int SCAN_DIV        = 1024,
    parameter int DEBOUNCE_CYCLES = 4096
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ena,
    input  logic [DIGITS*4-1:0]   sw,
    input  logic [DIGITS-1:0]     dp_in,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [DIGITS-1:0]     dig_sel,
    output logic                  upd
);

    localparam int W     = DIGITS * 4;
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int PRE_W = $clog2(SCAN_DIV);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

    logic [W-1:0]      s1_q, s1_d;
    logic [W-1:0]      cand_q, cand_d;
    logic [W-1:0]      value_q, value_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [PRE_W-1:0]  pre_q, pre_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              upd_q, upd_d;
    logic [6:0]        seg_q, seg_d;
    logic              dp_q, dp_d;
    logic [DIGITS-1:0] dig_sel_q, dig_sel_d;

    logic [3:0]        nib;
    logic              dp_sel;
    logic              blank;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    // Debounce and scan counters; everything holds while ena is low.
    always_comb begin
        s1_d    = s1_q;
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        value_d = value_q;
        upd_d   = 1'b0;
        pre_d   = pre_q;
        idx_d   = idx_q;
        if (ena) begin
            s1_d   = sw;
            cand_d = s1_q;
            if (s1_q != cand_q) begin
                cnt_d = '0;
            end else if (cnt_q == CNT_LAST) begin
                value_d = cand_q;
                upd_d   = (cand_q != value_q);
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            if (pre_q == PRE_LAST) begin
                pre_d = '0;
                idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
            end else begin
                pre_d = pre_q + PRE_W'(1);
            end
        end
    end

    always_comb begin
        nib    = 4'h0;
        dp_sel = 1'b0;
        blank  = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                nib    = value_q[4*i +: 4];
                dp_sel = dp_in[i];
            end
        end
`ifdef LEADING_ZERO_BLANK_EN
        // Walk down from the top nibble; a digit blanks if it and everything above it are zero.
        begin
            logic zero_run;
            zero_run = 1'b1;
            for (int i = DIGITS - 1; i >= 0; i--) begin
                zero_run = zero_run & (value_q[4*i +: 4] == 4'h0);
                if ((idx_q == IDX_W'(i)) && (i != 0)) begin
                    blank = zero_run;
                end
            end
        end
`endif
        seg_d     = '0;
        dp_d      = 1'b0;
        dig_sel_d = '0;
        if (ena) begin
            seg_d     = blank ? 7'h00 : hex7(nib);
            dp_d      = dp_sel;
            dig_sel_d = DIGITS'(1) << idx_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q      <= '0;
            cand_q    <= '0;
            value_q   <= '0;
            cnt_q     <= '0;
            pre_q     <= '0;
            idx_q     <= '0;
            upd_q     <= 1'b0;
            seg_q     <= '0;
            dp_q      <= 1'b0;
            dig_sel_q <= '0;
        end else begin
            s1_q      <= s1_d;
            cand_q    <= cand_d;
            value_q   <= value_d;
            cnt_q     <= cnt_d;
            pre_q     <= pre_d;
            idx_q     <= idx_d;
            upd_q     <= upd_d;
            seg_q     <= seg_d;
            dp_q      <= dp_d;
            dig_sel_q <= dig_sel_d;
        end
    end

    assign seg     = seg_q;
    assign dp      = dp_q;
    assign dig_sel = dig_sel_q;
    assign upd     = upd_q;

endmodule

// File: tb/tb_hex_scan_display.sv
// Bench for hex_scan_display: a sliding-window reference model predicts every output cycle
// into a queue, and an independent monitor compares the DUT against it.
module tb_hex_scan_display;

  localparam int DIGITS   = 4;
  localparam int SCAN_DIV = 4;
  localparam int DEB      = 8;
  localparam int W        = 13;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ena = 1'b1;
  logic [15:0] sw = '0;
  logic [3:0]  dp_in = '0;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  dig_sel;
  logic        upd;

  always #5 clk = ~clk;

  hex_scan_display #(
    .DIGITS(DIGITS),
    .SCAN_DIV(SCAN_DIV),
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk(clk),
    .rst(rst),
    .ena(ena),
    .sw(sw),
    .dp_in(dp_in),
    .seg(seg),
    .dp(dp),
    .dig_sel(dig_sel),
    .upd(upd)
  );

  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail = 0;

  logic [6:0] hex_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // Reference state: last DEB+1 sampled switch words, committed value, enabled-edge count.
  logic [15:0] hist[$];
  logic [15:0] m_value;
  int          m_k;

  function automatic logic [6:0] m_seg(input logic [15:0] v, input int d);
    logic [15:0] sh;
    sh = v >> (4 * d);
`ifdef LEADING_ZERO_BLANK_EN
    if (d > 0 && sh == 16'h0) return 7'h00;
`endif
    return hex_tab[sh[3:0]];
  endfunction

  always @(posedge clk) begin : model
    logic [W-1:0] e;
    logic [15:0]  c;
    logic         stable;
    int           d;
    e = '0;
    if (rst) begin
      hist.delete();
      hist.push_back(16'h0);
      hist.push_back(16'h0);
      m_value = '0;
      m_k = 0;
    end else if (ena) begin
      d = (m_k / SCAN_DIV) % DIGITS;
      e = {m_seg(m_value, d), dp_in[d], 4'(1 << d), 1'b0};
      // Commit once the newest DEB+1 samples are identical.
      stable = (hist.size() == DEB + 1);
      c = hist[hist.size() - 1];
      foreach (hist[j]) if (hist[j] != c) stable = 1'b0;
      if (stable) begin
        e[0] = (c != m_value);
        m_value = c;
      end
      hist.push_back(sw);
      if (hist.size() > DEB + 1) void'(hist.pop_front());
      m_k = (m_k + 1) % (SCAN_DIV * DIGITS);
    end
    exp_q.push_back(e);
  end

  always @(posedge clk) begin : monitor
    logic [W-1:0] got;
    logic [W-1:0] e;
    #1;
    got = {seg, dp, dig_sel, upd};
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL scoreboard_empty t=%0t got seg=%h dp=%b sel=%b upd=%b, no expected entry",
               $time, seg, dp, dig_sel, upd);
    end else begin
      e = exp_q.pop_front();
      if (got !== e) begin
        n_fail++;
        $display("FAIL out_word t=%0t got seg=%h dp=%b sel=%b upd=%b expected seg=%h dp=%b sel=%b upd=%b",
                 $time, seg, dp, dig_sel, upd, e[12:6], e[5], e[4:1], e[0]);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; ena = 1'b1; sw = '0; dp_in = '0;
    tick(2);
    rst = 1'b0;
    tick(3);
    sw = 16'h12AF;
    tick(14);
    sw = 16'h0001;
    tick(5);
    sw = 16'h12AF;
    tick(12);
    dp_in = 4'b1010;
    tick(20);
    ena = 1'b0;
    tick(10);
    ena = 1'b1;
    tick(10);
    sw = 16'h0005;
    tick(30);
    sw = 16'h0300;
    tick(30);
    // Change lands on the would-be commit cycle.
    sw = 16'hBEEF;
    tick(DEB);
    sw = 16'h1234;
    tick(14);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(6);
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        case ($urandom_range(0, 2))
          0: sw = 16'($urandom);
          1: sw = 16'($urandom_range(0, 255));
          default: sw = 16'($urandom_range(0, 15));
        endcase
      end
      dp_in = 4'($urandom);
      ena = ($urandom_range(0, 15) != 0);
      rst = ($urandom_range(0, 299) == 0);
      tick(1);
    end
    rst = 1'b0;
    ena = 1'b1;
    tick(3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
